// File: rtl/rarp_pkg.sv
// Shared constants and state type for the RARP transmit path.
// Optional padding (RARP_TX_PAD_EN) is resolved in rarp_trans.
package rarp_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;

  localparam logic [15:0] RARP_OP_REQUEST = 16'd3;
  localparam logic [15:0] RARP_OP_REPLY   = 16'd4;

  localparam int RARP_WORDS     = 7;
  localparam int RARP_PAD_WORDS = 5;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rarp_state_t;

endpackage

// File: rtl/rarp_word_mux.sv
// Combinational map from latched RARP fields and word index to the 32-bit
// big-endian packet word; any index past W6 yields a zero (pad) word.
module rarp_word_mux
  import rarp_pkg::*;
#(
  parameter logic [15:0] HTYPE = ARP_HTYPE_ETH,
  parameter logic [15:0] PTYPE = ARP_PTYPE_IPV4,
  parameter logic [7:0]  HLEN  = ARP_HLEN_ETH,
  parameter logic [7:0]  PLEN  = ARP_PLEN_IPV4,
  parameter int          IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [15:0]      operation,
  input  logic [47:0]      sha,
  input  logic [31:0]      spa,
  input  logic [47:0]      tha,
  input  logic [31:0]      tpa,
  output logic [31:0]      word
);

  always_comb begin
    word = '0;
    case (idx)
      IDX_W'(0): word = {HTYPE, PTYPE};
      IDX_W'(1): word = {HLEN, PLEN, operation};
      IDX_W'(2): word = sha[47:16];
      IDX_W'(3): word = {sha[15:0], spa[31:16]};
      IDX_W'(4): word = {spa[15:0], tha[47:32]};
      IDX_W'(5): word = tha[31:0];
      IDX_W'(6): word = tpa;
      default:   word = '0;
    endcase
  end

endmodule

// File: rtl/rarp_trans.sv
// RARP transmitter: latches packet fields on start and streams them as 32-bit
// words over a valid/ready handshake. Define RARP_TX_PAD_EN to append 5 zero words.
module rarp_trans
  import rarp_pkg::*;
#(
  parameter logic [15:0] HTYPE = ARP_HTYPE_ETH,
  parameter logic [15:0] PTYPE = ARP_PTYPE_IPV4,
  parameter logic [7:0]  HLEN  = ARP_HLEN_ETH,
  parameter logic [7:0]  PLEN  = ARP_PLEN_IPV4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] operation,
  input  logic [47:0] send_hdr_addr,
  input  logic [31:0] send_ip_addr,
  input  logic [47:0] target_hdr_addr,
  input  logic [31:0] target_ip_addr,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic        done
);

`ifdef RARP_TX_PAD_EN
  localparam int IDX_W    = 4;
  localparam int LAST_IDX = RARP_WORDS + RARP_PAD_WORDS - 1;
`else
  localparam int IDX_W    = 3;
  localparam int LAST_IDX = RARP_WORDS - 1;
`endif
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAST_IDX);

  rarp_state_t      state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             latch, done_nxt;
  logic [15:0]      op_q;
  logic [47:0]      sha_q, tha_q;
  logic [31:0]      spa_q, tpa_q;
  logic [31:0]      word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
      done  <= 1'b0;
      op_q  <= '0;
      sha_q <= '0;
      spa_q <= '0;
      tha_q <= '0;
      tpa_q <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      done  <= done_nxt;
      if (latch) begin
        op_q  <= operation;
        sha_q <= send_hdr_addr;
        spa_q <= send_ip_addr;
        tha_q <= target_hdr_addr;
        tpa_q <= target_ip_addr;
      end
    end
  end

  // tx_valid is decoded from state alone, so a handshake is just tx_ready in SEND.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    latch     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          latch     = 1'b1;
          idx_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx == IDX_LAST) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  rarp_word_mux #(
    .HTYPE (HTYPE),
    .PTYPE (PTYPE),
    .HLEN  (HLEN),
    .PLEN  (PLEN),
    .IDX_W (IDX_W)
  ) u_word_mux (
    .idx       (idx),
    .operation (op_q),
    .sha       (sha_q),
    .spa       (spa_q),
    .tha       (tha_q),
    .tpa       (tpa_q),
    .word      (word)
  );

  assign busy     = (state == SEND);
  assign tx_valid = busy;
  assign tx_last  = busy && (idx == IDX_LAST);
  assign tx_data  = busy ? word : '0;

endmodule

// File: tb/tb_rarp_trans.sv
// Self-checking bench for rarp_trans: directed scenarios plus randomized
// packets with random back-pressure, checked against a byte-level packet model.
module tb_rarp_trans;
  import rarp_pkg::*;

`ifdef RARP_TX_PAD_EN
  localparam int NW = 12;
`else
  localparam int NW = 7;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] operation = '0;
  logic [47:0] send_hdr_addr = '0;
  logic [31:0] send_ip_addr = '0;
  logic [47:0] target_hdr_addr = '0;
  logic [31:0] target_ip_addr = '0;
  logic        tx_ready = 1'b0;
  logic [31:0] tx_data;
  logic        tx_valid, tx_last, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] cap_data[$];
  logic        cap_last[$];
  int          done_cnt, done_cyc, stall_err;

  rarp_trans dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .operation       (operation),
    .send_hdr_addr   (send_hdr_addr),
    .send_ip_addr    (send_ip_addr),
    .target_hdr_addr (target_hdr_addr),
    .target_ip_addr  (target_ip_addr),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_last         (tx_last),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // Packet model: lay the RARP body out as bytes, zero-padded, then cut into words.
  function automatic void build_model(input logic [15:0] op, input logic [47:0] sha,
                                      input logic [31:0] spa, input logic [47:0] tha,
                                      input logic [31:0] tpa);
    logic [7:0] b[48];
    for (int i = 0; i < 48; i++) b[i] = 8'h00;
    b[0] = 8'h00; b[1] = 8'h01; b[2] = 8'h08; b[3] = 8'h00;
    b[4] = 8'd6;  b[5] = 8'd4;  b[6] = op[15:8]; b[7] = op[7:0];
    for (int i = 0; i < 6; i++) b[8 + i]  = sha[47 - 8*i -: 8];
    for (int i = 0; i < 4; i++) b[14 + i] = spa[31 - 8*i -: 8];
    for (int i = 0; i < 6; i++) b[18 + i] = tha[47 - 8*i -: 8];
    for (int i = 0; i < 4; i++) b[24 + i] = tpa[31 - 8*i -: 8];
    exp_q.delete();
    for (int k = 0; k < NW; k++) exp_q.push_back({b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]});
  endfunction

  // Drive fields and a one-cycle start; returns at the negedge where W0 should be valid.
  task automatic kick(input logic [15:0] op, input logic [47:0] sha, input logic [31:0] spa,
                      input logic [47:0] tha, input logic [31:0] tpa);
    @(negedge clk);
    operation = op; send_hdr_addr = sha; send_ip_addr = spa;
    target_hdr_addr = tha; target_ip_addr = tpa;
    build_model(op, sha, spa, tha, tpa);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Collect handshaken words until done; mode 0 ready=1, 1 toggling, 2 random.
  task automatic capture(input int mode, input int inject_at, input int max_cyc);
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    logic        r, injected = 1'b0;
    cap_data.delete(); cap_last.delete();
    done_cnt = 0; done_cyc = -1; stall_err = 0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      start = 1'b0;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        break;
      end
      if (prev_stall && (!tx_valid || tx_data !== prev_data || tx_last !== prev_last))
        stall_err++;
      if (inject_at >= 0 && !injected && tx_valid && cap_data.size() == inject_at) begin
        injected = 1'b1;
        start = 1'b1;
        operation = 16'hBEEF;
        send_hdr_addr = {$urandom, $urandom};
        send_ip_addr = $urandom;
        target_hdr_addr = {$urandom, $urandom};
        target_ip_addr = $urandom;
      end
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = (cyc % 2 == 1);
      else r = 1'($urandom_range(0, 1));
      tx_ready = r;
      if (tx_valid && r) begin
        cap_data.push_back(tx_data);
        cap_last.push_back(tx_last);
      end
      prev_stall = tx_valid && !r;
      prev_data = tx_data;
      prev_last = tx_last;
      @(negedge clk);
    end
    start = 1'b0;
    tx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({tx_valid, tx_last, busy, done} !== 4'b0000 || tx_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b l=%b b=%b d=%b data=%h expected all 0",
               tx_valid, tx_last, busy, done, tx_data);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tx_valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after_release got v=%b b=%b d=%b expected 0", tx_valid, busy, done);
    end
  endtask

  task automatic test_basic();
    logic [31:0] spec_w[7];
    spec_w = '{32'h00010800, 32'h06040003, 32'h00112233, 32'h44550000,
               32'h00000011, 32'h22334455, 32'h00000000};
    kick(RARP_OP_REQUEST, 48'h0011_2233_4455, 32'h0, 48'h0011_2233_4455, 32'h0);
    n_checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 32'h00010800) begin
      n_fail++;
      $display("FAIL basic_first got busy=%b v=%b data=%h expected 1 1 00010800",
               busy, tx_valid, tx_data);
    end
    capture(0, -1, 40);
    n_checks++;
    if (cap_data.size() != NW) begin
      n_fail++;
      $display("FAIL basic_count got %0d expected %0d", cap_data.size(), NW);
    end
    for (int k = 0; k < NW && k < cap_data.size(); k++) begin
      n_checks++;
      if (cap_data[k] !== ((k < 7) ? spec_w[k] : 32'h0) || cap_last[k] !== (k == NW - 1)) begin
        n_fail++;
        $display("FAIL basic_w%0d got %h last=%b expected %h last=%b", k, cap_data[k],
                 cap_last[k], (k < 7) ? spec_w[k] : 32'h0, k == NW - 1);
      end
    end
    n_checks++;
    if (done_cyc != NW + 1) begin
      n_fail++;
      $display("FAIL basic_done_cycle got %0d expected %0d", done_cyc, NW + 1);
    end
    @(negedge clk);
    n_checks++;
    if ({done, busy, tx_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_after got d=%b b=%b v=%b expected 000", done, busy, tx_valid);
    end
  endtask

  task automatic test_backpressure();
    kick(RARP_OP_REPLY, 48'h0011_2233_4455, 32'hC0A8_0001, 48'h0011_2233_4455, 32'hC0A8_0064);
    capture(1, -1, 80);
    n_checks++;
    if (cap_data.size() != NW || stall_err != 0 || done_cyc != 2 * NW) begin
      n_fail++;
      $display("FAIL bp_shape got n=%0d stall_err=%0d done_cyc=%0d expected %0d 0 %0d",
               cap_data.size(), stall_err, done_cyc, NW, 2 * NW);
    end
    for (int k = 0; k < NW && k < cap_data.size(); k++) begin
      n_checks++;
      if (cap_data[k] !== exp_q[k] || cap_last[k] !== (k == NW - 1)) begin
        n_fail++;
        $display("FAIL bp_w%0d got %h last=%b expected %h", k, cap_data[k], cap_last[k], exp_q[k]);
      end
    end
    if (cap_data.size() >= 7) begin
      n_checks++;
      if (cap_data[3] !== 32'h4455C0A8 || cap_data[6] !== 32'hC0A80064) begin
        n_fail++;
        $display("FAIL bp_w3_w6 got %h %h expected 4455c0a8 c0a80064", cap_data[3], cap_data[6]);
      end
    end
  endtask

  task automatic test_start_busy();
    int extra_done = 0;
    kick(16'd3, {$urandom, $urandom}, $urandom, {$urandom, $urandom}, $urandom);
    capture(0, 3, 40);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) extra_done++;
      n_checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_start_queued cyc=%0d got v=%b b=%b expected 0", i, tx_valid, busy);
      end
    end
    n_checks++;
    if (cap_data.size() != NW || done_cnt + extra_done != 1) begin
      n_fail++;
      $display("FAIL busy_start_count got n=%0d dones=%0d expected %0d 1",
               cap_data.size(), done_cnt + extra_done, NW);
    end
    for (int k = 0; k < NW && k < cap_data.size(); k++) begin
      n_checks++;
      if (cap_data[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL busy_start_w%0d got %h expected %h", k, cap_data[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int total;
    logic [31:0] exp2[$];
    kick(16'd4, {$urandom, $urandom}, $urandom, {$urandom, $urandom}, $urandom);
    capture(0, -1, 40);
    total = done_cyc;
    n_checks++;
    if (cap_data.size() != NW || cap_data[0] !== exp_q[0] || cap_data[NW-1] !== exp_q[NW-1]) begin
      n_fail++;
      $display("FAIL b2b_first got n=%0d expected %0d", cap_data.size(), NW);
    end
    // done is high at this negedge; request the next packet in the same cycle
    operation = 16'd3; send_hdr_addr = {$urandom, $urandom}; send_ip_addr = $urandom;
    target_hdr_addr = {$urandom, $urandom}; target_ip_addr = $urandom;
    build_model(operation, send_hdr_addr, send_ip_addr, target_hdr_addr, target_ip_addr);
    exp2 = exp_q;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== exp2[0]) begin
      n_fail++;
      $display("FAIL b2b_w0_next got v=%b data=%h expected 1 %h", tx_valid, tx_data, exp2[0]);
    end
    capture(0, -1, 40);
    total += done_cyc;
    n_checks++;
    if (total != 2 * (NW + 1)) begin
      n_fail++;
      $display("FAIL b2b_total_cycles got %0d expected %0d", total, 2 * (NW + 1));
    end
    for (int k = 0; k < NW && k < cap_data.size(); k++) begin
      n_checks++;
      if (cap_data[k] !== exp2[k]) begin
        n_fail++;
        $display("FAIL b2b_second_w%0d got %h expected %h", k, cap_data[k], exp2[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    kick(16'd3, {$urandom, $urandom}, $urandom, {$urandom, $urandom}, $urandom);
    tx_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== exp_q[4]) begin
      n_fail++;
      $display("FAIL rstmid_w4 got v=%b data=%h expected 1 %h", tx_valid, tx_data, exp_q[4]);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({tx_valid, tx_last, busy, done} !== 4'b0000 || tx_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_async got v=%b l=%b b=%b d=%b data=%h expected 0",
               tx_valid, tx_last, busy, done, tx_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst = 1'b1;
    tx_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_checks++;
    if (dones != 0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_done got dones=%0d v=%b expected 0 0", dones, tx_valid);
    end
    kick(16'd4, {$urandom, $urandom}, $urandom, {$urandom, $urandom}, $urandom);
    capture(0, -1, 40);
    n_checks++;
    if (cap_data.size() != NW || done_cyc != NW + 1) begin
      n_fail++;
      $display("FAIL rstmid_restart got n=%0d done_cyc=%0d expected %0d %0d",
               cap_data.size(), done_cyc, NW, NW + 1);
    end
    for (int k = 0; k < NW && k < cap_data.size(); k++) begin
      n_checks++;
      if (cap_data[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL rstmid_w%0d got %h expected %h", k, cap_data[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      kick(16'($urandom), {$urandom, $urandom}, $urandom, {$urandom, $urandom}, $urandom);
      capture(2, -1, 400);
      n_checks++;
      if (cap_data.size() != NW || done_cnt != 1 || stall_err != 0) begin
        n_fail++;
        $display("FAIL rand%0d_shape got n=%0d done=%0d stall_err=%0d expected %0d 1 0",
                 p, cap_data.size(), done_cnt, stall_err, NW);
      end
      for (int k = 0; k < NW && k < cap_data.size(); k++) begin
        n_checks++;
        if (cap_data[k] !== exp_q[k] || cap_last[k] !== (k == NW - 1)) begin
          n_fail++;
          $display("FAIL rand%0d_w%0d got %h last=%b expected %h last=%b", p, k,
                   cap_data[k], cap_last[k], exp_q[k], k == NW - 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
